// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg
// Shared definitions for the instruction fetch stage: default reset PC,
// the canonical NOP word, the fetch FSM state encoding, the queue entry
// layout and a PC alignment helper.
// Ports: none (package).

package inst_fetch_unit_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

   // IDLE: no request. BUSY: request to fetch_pc outstanding.
   // DROP: request to a stale address outstanding; its data is discarded.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Redirect targets are word aligned by clearing the two low bits.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & ~32'd3;
   endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if
// Instruction memory request/acknowledge bus.
// Signals:
//   imem_req   - fetch request, held until imem_ack
//   imem_addr  - fetch address, stable while the request is pending
//   imem_ack   - imem_rdata valid this cycle
//   imem_rdata - fetched instruction word
// Modports: master (fetch unit), slave (instruction memory).

interface inst_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/inst_fetch_unit_fetch_queue.sv
// inst_fetch_unit_fetch_queue
// Two-entry FIFO of {pc, inst} entries with a registered head.
// Ports:
//   clk, rst   - clock, asynchronous active-low reset
//   push       - write push_entry this cycle
//   pop        - drop the head this cycle (ignored when empty)
//   flush      - empty the queue; overrides push and pop
//   push_entry - entry to write
//   count      - number of valid entries (0..2)
//   head       - oldest entry (meaningful only when count != 0)

module inst_fetch_unit_fetch_queue
   import inst_fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_entry,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t entry0;
   fetch_entry_t entry1;
   logic [1:0]   count_q;
   logic         pop_ok;

   assign pop_ok = pop && (count_q != 2'd0);
   assign count  = count_q;
   assign head   = entry0;

   // entry0 is always the head. A pop shifts entry1 down; a simultaneous
   // push lands in whichever slot becomes the new tail.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entry0  <= '0;
         entry1  <= '0;
         count_q <= 2'd0;
      end else if (flush) begin
         count_q <= 2'd0;
      end else begin
         case ({push, pop_ok})
            2'b10: begin
               if (count_q == 2'd0) begin
                  entry0  <= push_entry;
                  count_q <= 2'd1;
               end else if (count_q == 2'd1) begin
                  entry1  <= push_entry;
                  count_q <= 2'd2;
               end
            end
            2'b01: begin
               entry0  <= entry1;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  entry0 <= push_entry;
               end else begin
                  entry0 <= entry1;
                  entry1 <= push_entry;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
// Instruction fetch stage: owns the program counter, fetches over a
// variable-latency req/ack bus, buffers words in a 2-entry queue and
// presents {pc, inst} to decode. Redirects flush the queue and refetch.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   imem           - instruction memory bus (master side)
//   redirect_valid - one-cycle redirect pulse from execute
//   redirect_pc    - redirect target (low two bits ignored)
//   if_valid       - queue head valid
//   if_ready       - decode accepts head this cycle
//   if_pc          - head PC (0 when empty)
//   if_inst        - head instruction (NOP_INST when empty)

module inst_fetch_unit
   import inst_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
)
(
   input  logic                     clk,
   input  logic                     rst,
   inst_fetch_unit_if.master        imem,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   output logic                     if_valid,
   input  logic                     if_ready,
   output logic [31:0]              if_pc,
   output logic [31:0]              if_inst
);

   fetch_state_t state;
   fetch_state_t state_next;
   logic [31:0]  fetch_pc;
   logic [31:0]  fetch_pc_next;
   logic [31:0]  addr_q;
   logic [31:0]  target;
   logic         push;
   logic         pop;
   logic [1:0]   count;
   logic [1:0]   count_next;
   fetch_entry_t head;
   fetch_entry_t push_entry;

   inst_fetch_unit_fetch_queue u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .flush      (redirect_valid),
      .push_entry (push_entry),
      .count      (count),
      .head       (head)
   );

   assign push_entry = '{pc: fetch_pc, inst: imem.imem_rdata};
   assign imem.imem_req  = (state != IDLE);
   assign imem.imem_addr = addr_q;
   assign if_valid = (count != 2'd0);
   assign if_pc    = if_valid ? head.pc : 32'd0;
   assign if_inst  = if_valid ? head.inst : NOP_INST;

   // The address register follows fetch_pc except while a stale request is
   // still pending (DROP), where the bus address must stay put until the
   // stale ack arrives even though fetch_pc already holds the new target.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         addr_q   <= RESET_PC;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         if (state_next != DROP) begin
            addr_q <= fetch_pc_next;
         end
      end
   end

   // Next-state and queue control. A redirect beats push and pop; staying
   // in or entering BUSY requires room for the next word, so an ack never
   // finds the queue full.
   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      target        = align_pc(redirect_pc);
      pop           = if_valid && if_ready;
      push          = (state == BUSY) && imem.imem_ack && !redirect_valid;
      if (redirect_valid) begin
         count_next = 2'd0;
      end else begin
         count_next = count + {1'b0, push} - {1'b0, pop};
      end

      case (state)
         IDLE: begin
            if (redirect_valid) begin
               fetch_pc_next = target;
               state_next    = BUSY;
            end else if (count < 2'd2) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (redirect_valid) begin
               fetch_pc_next = target;
               state_next    = imem.imem_ack ? BUSY : DROP;
            end else if (imem.imem_ack) begin
               fetch_pc_next = fetch_pc + 32'd4;
               state_next    = (count_next < 2'd2) ? BUSY : IDLE;
            end
         end
         DROP: begin
            if (redirect_valid) begin
               fetch_pc_next = target;
               state_next    = imem.imem_ack ? BUSY : DROP;
            end else if (imem.imem_ack) begin
               state_next = BUSY;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit
// Directed bench for inst_fetch_unit. The memory model returns
// {16'hCAFE, addr[15:0]} and acks either in the request cycle (zero-wait
// mode) or when the bench raises manual_ack.

module tb_inst_fetch_unit;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        zw_mode;
   logic        manual_ack;
   int          assert_count;
   int          fail_count;

   inst_fetch_unit_if ifc ();

   assign ifc.imem_rdata = {16'hCAFE, ifc.imem_addr[15:0]};
   assign ifc.imem_ack   = zw_mode ? ifc.imem_req : manual_ack;

   inst_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .NOP_INST (32'h0000_0013)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (ifc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_inst        (if_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic ack, input logic ready, input logic redir, input logic [31:0] rpc);
      manual_ack     = ack;
      if_ready       = ready;
      redirect_valid = redir;
      redirect_pc    = rpc;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      assert_count = 0;
      fail_count   = 0;
      rst          = 1'b0;
      zw_mode      = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

      // Reset values
      #12;
      checkOutput("rst_req", {31'd0, ifc.imem_req}, 32'd0);
      checkOutput("rst_addr", ifc.imem_addr, 32'h0);
      checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("rst_pc", if_pc, 32'h0);
      checkOutput("rst_inst", if_inst, 32'h13);

      // Zero-wait streaming, then a redirect near the top of memory to wrap
      @(negedge clk);
      rst = 1'b1;
      tick();
      checkOutput("t1_req0", {31'd0, ifc.imem_req}, 32'd1);
      checkOutput("t1_addr0", ifc.imem_addr, 32'h0);
      checkOutput("t1_valid0", {31'd0, if_valid}, 32'd0);
      tick();
      checkOutput("t1_addr4", ifc.imem_addr, 32'h4);
      checkOutput("t1_valid1", {31'd0, if_valid}, 32'd1);
      checkOutput("t1_pc0", if_pc, 32'h0);
      checkOutput("t1_inst0", if_inst, 32'hCAFE_0000);
      tick();
      checkOutput("t1_addr8", ifc.imem_addr, 32'h8);
      checkOutput("t1_pc4", if_pc, 32'h4);
      checkOutput("t1_inst4", if_inst, 32'hCAFE_0004);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
      tick();
      checkOutput("wrap_addr", ifc.imem_addr, 32'hFFFF_FFFC);
      checkOutput("wrap_valid0", {31'd0, if_valid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("wrap_addr0", ifc.imem_addr, 32'h0);
      checkOutput("wrap_pc", if_pc, 32'hFFFF_FFFC);
      checkOutput("wrap_inst", if_inst, 32'hCAFE_FFFC);
      tick();
      checkOutput("wrap_addr4", ifc.imem_addr, 32'h4);
      checkOutput("wrap_pc0", if_pc, 32'h0);

      // Backpressure: two acks fill the queue, then drain and resume
      zw_mode = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      resetDut();
      checkOutput("t2_req1", {31'd0, ifc.imem_req}, 32'd1);
      checkOutput("t2_addr0", ifc.imem_addr, 32'h0);
      tick();
      checkOutput("t2_addr4", ifc.imem_addr, 32'h4);
      tick();
      checkOutput("t2_idle_req", {31'd0, ifc.imem_req}, 32'd0);
      checkOutput("t2_full_valid", {31'd0, if_valid}, 32'd1);
      checkOutput("t2_idle_addr", ifc.imem_addr, 32'h8);
      tick();
      checkOutput("t2_hold_req", {31'd0, ifc.imem_req}, 32'd0);
      checkOutput("t2_head0", if_pc, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("t2_drain_req", {31'd0, ifc.imem_req}, 32'd0);
      checkOutput("t2_head4", if_pc, 32'h4);
      checkOutput("t2_inst4", if_inst, 32'hCAFE_0004);
      tick();
      checkOutput("t2_resume_req", {31'd0, ifc.imem_req}, 32'd1);
      checkOutput("t2_resume_addr", ifc.imem_addr, 32'h8);
      checkOutput("t2_empty", {31'd0, if_valid}, 32'd0);
      tick();
      checkOutput("t2_head8", if_pc, 32'h8);

      // Slow ack with a redirect while waiting: stale data dropped
      zw_mode = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      resetDut();
      checkOutput("t3_addr0", ifc.imem_addr, 32'h0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
      tick();
      checkOutput("t3_drop_req", {31'd0, ifc.imem_req}, 32'd1);
      checkOutput("t3_drop_addr", ifc.imem_addr, 32'h0);
      checkOutput("t3_drop_valid", {31'd0, if_valid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("t3_stale_addr", ifc.imem_addr, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("t3_target_addr", ifc.imem_addr, 32'h100);
      checkOutput("t3_no_stale", {31'd0, if_valid}, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("t3_pc", if_pc, 32'h100);
      checkOutput("t3_inst", if_inst, 32'hCAFE_0100);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

      // Redirect with ignored ack and pop while full
      zw_mode = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      resetDut();
      tick();
      tick();
      checkOutput("t4_full_req", {31'd0, ifc.imem_req}, 32'd0);
      checkOutput("t4_full_pc", if_pc, 32'h0);
      zw_mode = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h203);
      tick();
      checkOutput("t4_req", {31'd0, ifc.imem_req}, 32'd1);
      checkOutput("t4_addr", ifc.imem_addr, 32'h200);
      checkOutput("t4_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("t4_inst_nop", if_inst, 32'h13);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);

      // Back-to-back redirects while dropping
      zw_mode = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      resetDut();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
      tick();
      checkOutput("t5_drop1_addr", ifc.imem_addr, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h80);
      tick();
      checkOutput("t5_drop2_addr", ifc.imem_addr, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      checkOutput("t5_target_addr", ifc.imem_addr, 32'h80);
      checkOutput("t5_valid", {31'd0, if_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      tick();
      checkOutput("t5_pc", if_pc, 32'h80);
      checkOutput("t5_inst", if_inst, 32'hCAFE_0080);
      checkOutput("t5_next_addr", ifc.imem_addr, 32'h84);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

      // Asynchronous reset in the middle of a pending request
      tick();
      checkOutput("t6_pre_req", {31'd0, ifc.imem_req}, 32'd1);
      checkOutput("t6_pre_valid", {31'd0, if_valid}, 32'd1);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("t6_async_req", {31'd0, ifc.imem_req}, 32'd0);
      checkOutput("t6_async_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("t6_async_addr", ifc.imem_addr, 32'h0);
      checkOutput("t6_async_inst", if_inst, 32'h13);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      zw_mode = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      rst = 1'b1;
      tick();
      checkOutput("t6_refetch_req", {31'd0, ifc.imem_req}, 32'd1);
      checkOutput("t6_refetch_addr", ifc.imem_addr, 32'h0);
      tick();
      checkOutput("t6_refetch_pc", if_pc, 32'h0);
      checkOutput("t6_refetch_inst", if_inst, 32'hCAFE_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
